// File: rtl/chaser_pkg.sv
// Shared definitions for the LED chaser: opcodes, modes, FSM states and
// the position-stepping helpers used by the controller.
package chaser_pkg;

  localparam int NUM_LEDS = 10;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_SPEED = 2'b11;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam logic [NUM_LEDS-1:0] POS_FIRST = 10'h001;
  localparam logic [NUM_LEDS-1:0] POS_LAST  = 10'h200;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_LEDS-1:0] pos;
    logic                dir_up;
  } step_t;

  function automatic logic is_onehot(input logic [NUM_LEDS-1:0] v);
    return (v != '0) && ((v & (v - 10'd1)) == '0);
  endfunction

  // Mode 3 is reserved and behaves as UP.
  function automatic logic [1:0] norm_mode(input logic [1:0] arg);
    return ((arg == MODE_DOWN) || (arg == MODE_BOUNCE)) ? arg : MODE_UP;
  endfunction

  function automatic logic [3:0] led_index(input logic [NUM_LEDS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (v[i]) idx = 4'(i + 1);
    end
    return idx;
  endfunction

  // A corrupted (non one-hot) position recovers to bit0 on the next step.
  function automatic step_t next_step(input logic [NUM_LEDS-1:0] pos,
                                      input logic [1:0] mode,
                                      input logic dir_up);
    step_t r;
    r.pos    = pos;
    r.dir_up = dir_up;
    if (!is_onehot(pos)) begin
      r.pos    = POS_FIRST;
      r.dir_up = 1'b1;
    end else begin
      case (mode)
        MODE_DOWN: r.pos = {pos[0], pos[NUM_LEDS-1:1]};
        MODE_BOUNCE: begin
          if (dir_up && pos[NUM_LEDS-1]) begin
            r.pos    = {1'b0, pos[NUM_LEDS-1:1]};
            r.dir_up = 1'b0;
          end else if (dir_up) begin
            r.pos = {pos[NUM_LEDS-2:0], 1'b0};
          end else if (pos[0]) begin
            r.pos    = {pos[NUM_LEDS-2:0], 1'b0};
            r.dir_up = 1'b1;
          end else begin
            r.pos = {1'b0, pos[NUM_LEDS-1:1]};
          end
        end
        default: r.pos = {pos[NUM_LEDS-2:0], pos[NUM_LEDS-1]};
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/chaser_ctrl_step_timer.sv
// Step prescaler: counts enabled cycles and pulses tc when the count
// reaches BASE_DIV*(speed+1), clearing itself on that same cycle.
module step_timer #(
  parameter int BASE_DIV = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] speed,
  output logic       tc
);

  logic [26:0] cnt_r;
  logic [26:0] period_s;
  logic [26:0] cnt_inc_s;

  // Period from current speed; tc compares the incremented count so a
  // period that shrank below the count fires on the next enabled cycle.
  always_comb begin
    period_s  = 27'(BASE_DIV) * (27'(speed) + 27'd1);
    cnt_inc_s = cnt_r + 27'd1;
    tc        = enable && !clear && (cnt_inc_s >= period_s);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 27'd0;
    end else if (clear) begin
      cnt_r <= 27'd0;
    end else if (enable) begin
      cnt_r <= tc ? 27'd0 : cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/chaser_ctrl.sv
// LED chaser controller: command handshake, STOP/RUN/PAUSE FSM and the
// one-hot position register with its led index, all outputs registered.
module chaser_ctrl #(
  parameter int BASE_DIV = 6_250_000,
  parameter int NUM_LEDS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [3:0]          cmd_arg,
  output logic [NUM_LEDS-1:0] outdata,
  output logic [3:0]          led,
  output logic                step_pulse,
  output logic                running
);
  import chaser_pkg::*;

  state_t              state_r, state_n;
  logic [1:0]          mode_r, mode_n;
  logic                dir_up_r, dir_up_n;
  logic [3:0]          speed_r, speed_n;
  logic [NUM_LEDS-1:0] outdata_r, pos_n;
  logic [3:0]          led_r;
  logic                pulse_r, pulse_n;
  logic                running_r;
  logic                cmd_ready_r;
  logic                accept_s;
  logic                tmr_en_s, tmr_clr_s, tc_s;
  step_t               nxt_s;

  assign accept_s   = cmd_valid && cmd_ready_r;
  assign cmd_ready  = cmd_ready_r;
  assign outdata    = outdata_r;
  assign led        = led_r;
  assign step_pulse = pulse_r;
  assign running    = running_r;

  // Timer control: STOP and PAUSE accepts freeze the count so a
  // coinciding terminal count is suppressed.
  always_comb begin
    tmr_en_s  = (state_r == ST_RUN);
    tmr_clr_s = 1'b0;
    if (accept_s) begin
      case (cmd_op)
        OP_STOP: begin
          tmr_en_s  = 1'b0;
          tmr_clr_s = 1'b1;
        end
        OP_PAUSE: tmr_en_s  = 1'b0;
        OP_START: tmr_clr_s = (state_r == ST_STOP);
        default:  tmr_clr_s = 1'b0;
      endcase
    end else begin
      tmr_clr_s = 1'b0;
    end
  end

  step_timer #(.BASE_DIV(BASE_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (tmr_en_s),
    .clear  (tmr_clr_s),
    .speed  (speed_r),
    .tc     (tc_s)
  );

  // Next-state: apply the accepted command, then a pending step using the
  // post-command mode.
  always_comb begin
    state_n  = state_r;
    mode_n   = mode_r;
    dir_up_n = dir_up_r;
    speed_n  = speed_r;
    pos_n    = outdata_r;
    pulse_n  = 1'b0;
    if (accept_s) begin
      case (cmd_op)
        OP_START: begin
          mode_n  = norm_mode(cmd_arg[1:0]);
          state_n = ST_RUN;
          if (state_r == ST_STOP) begin
            pos_n    = (mode_n == MODE_DOWN) ? POS_LAST : POS_FIRST;
            dir_up_n = 1'b1;
          end else begin
            pos_n = outdata_r;
          end
        end
        OP_STOP: begin
          state_n = ST_STOP;
          pos_n   = '0;
        end
        OP_PAUSE: begin
          if (state_r == ST_RUN) begin
            state_n = ST_PAUSE;
          end else if (state_r == ST_PAUSE) begin
            state_n = ST_RUN;
          end else begin
            state_n = state_r;
          end
        end
        OP_SPEED: speed_n = cmd_arg;
        default:  state_n = state_r;
      endcase
    end else begin
      state_n = state_r;
    end
    nxt_s = next_step(outdata_r, mode_n, dir_up_r);
    if (tc_s) begin
      pos_n    = nxt_s.pos;
      dir_up_n = nxt_s.dir_up;
      pulse_n  = 1'b1;
    end else begin
      pulse_n = 1'b0;
    end
  end

  // State and output registers; led derives from the same next position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_STOP;
      mode_r      <= MODE_UP;
      dir_up_r    <= 1'b1;
      speed_r     <= 4'd15;
      outdata_r   <= '0;
      led_r       <= 4'd0;
      pulse_r     <= 1'b0;
      running_r   <= 1'b0;
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      mode_r      <= mode_n;
      dir_up_r    <= dir_up_n;
      speed_r     <= speed_n;
      outdata_r   <= pos_n;
      led_r       <= led_index(pos_n);
      pulse_r     <= pulse_n;
      running_r   <= (state_n == ST_RUN);
      cmd_ready_r <= !accept_s;
    end
  end

endmodule

// File: doc/chaser_ctrl.md
CHASER_CTRL -- requirements
Module: chaser_ctrl

Interface
REQ-001 SHALL have parameter BASE_DIV, default 6_250_000; clocks per step unit (100 MHz / 16).
REQ-002 SHALL have parameter NUM_LEDS, default 10; chaser width, fixed at 10 in this revision.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, 100 MHz, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit; command request.
REQ-006 SHALL have port cmd_ready, output, 1 bit; command may be accepted this cycle.
REQ-007 SHALL have port cmd_op, input, 2 bits; 00 START, 01 STOP, 10 PAUSE toggle, 11 SET_SPEED.
REQ-008 SHALL have port cmd_arg, input, 4 bits; START uses arg[1:0] as mode (0 UP, 1 DOWN, 2 BOUNCE, 3 treated as UP); SET_SPEED uses arg[3:0] as speed.
REQ-009 SHALL have port outdata, output, 10 bits; one-hot light position, all-zero when stopped.
REQ-010 SHALL have port led, output, 4 bits; index 1..10 of the set outdata bit, 0 when outdata is zero.
REQ-011 SHALL have port step_pulse, output, 1 bit; high for the one cycle in which outdata advanced.
REQ-012 SHALL have port running, output, 1 bit; high in state RUN only.

Function
REQ-013 SHALL be a three-state FSM: STOP, RUN, PAUSE.
REQ-014 SHALL accept a command on a cycle with cmd_valid and cmd_ready both high.
- cmd_ready SHALL be low during reset and for the one cycle after each accept.
- Maximum rate is one command per two cycles.
REQ-015 SHALL implement the step period as BASE_DIV*(speed+1) clocks, using a 27-bit prescaler.
- The prescaler counts only in RUN.
- It clears when it reaches the period, and the step fires on that cycle.
REQ-016 SHALL step in mode UP as outdata << 1, with bit9 wrapping to bit0.
REQ-017 SHALL step in mode DOWN as outdata >> 1, with bit0 wrapping to bit9.
REQ-018 SHALL step in mode BOUNCE by moving in the current direction.
- Direction reverses at the ends: bit9 goes to bit8, and bit0 goes to bit1.
REQ-019 SHALL handle START from STOP as follows.
- Go to RUN.
- On the next edge, load bit0 (UP or BOUNCE, direction up) or bit9 (DOWN).
- Clear the prescaler.
- Do not assert step_pulse.
REQ-020 SHALL handle START in RUN or PAUSE as follows.
- Change the mode only.
- Keep the position and the prescaler.
- Enter RUN.
- A BOUNCE direction continues unchanged.
REQ-021 SHALL handle STOP in any state as follows.
- Go to STOP.
- Set outdata to 0 and led to 0.
- Clear the prescaler.
- Keep the speed.
REQ-022 SHALL handle PAUSE as follows.
- RUN goes to PAUSE; PAUSE goes to RUN.
- In PAUSE, outdata and the prescaler hold.
- In STOP, PAUSE is ignored but still accepted.
REQ-023 SHALL handle SET_SPEED in any state by updating speed.
- If the prescaler is already at or above the new period, the step fires on the next RUN cycle.
REQ-024 SHALL resolve an accept coinciding with a prescaler terminal count as follows.
- STOP and PAUSE win, and the step is suppressed.
- START mode change: the step is taken using the new mode.
- SET_SPEED: the step is taken and the prescaler clears.
REQ-025 SHALL keep outdata one-hot or zero at all times.
- If outdata is ever invalid in RUN, it reloads bit0 on the next step.
REQ-026 SHALL register led in the same cycle as outdata, with zero-cycle skew between them.

Reset
REQ-027 SHALL, on rst high at a clock edge, set the following:
- state STOP;
- outdata 0, led 0;
- step_pulse 0, running 0, cmd_ready 0;
- speed 15, mode UP, direction up;
- prescaler 0.
REQ-028 SHALL give rst priority over any command.
- Reset asserted mid-RUN returns to the REQ-027 values on that edge.
- cmd_ready rises on the first cycle after rst goes low.

Structure
REQ-029 SHALL place in shared package chaser_pkg:
- the opcode constants;
- the mode constants;
- the FSM state encoding;
- NUM_LEDS.
REQ-030 SHALL use one sub-module, step_timer, containing the following:
- prescaler, period compute and terminal-count pulse;
- inputs: enable, clear, speed.
REQ-031 SHALL keep the FSM and position register in chaser_ctrl.

Verification (BASE_DIV=4)
REQ-032 Reset release, then START UP with speed 0: outdata=0x001 and led=1, then step_pulse every 4 clocks; after 10 steps outdata=0x001 again.
REQ-033 START DOWN, speed 1: outdata=0x200 and led=10; a step every 8 clocks; 0x001 wraps to 0x200.
REQ-034 START BOUNCE, speed 0: sequence 0x001..0x200, then 0x100; after 18 steps outdata=0x001 and the next step gives 0x002.
REQ-035 RUN at 0x008, PAUSE for 20 clocks, then PAUSE again: outdata holds 0x008 with no step_pulse; the next step occurs at the remaining prescaler count; led=4 throughout.
REQ-036 Back-to-back cmd_valid: cmd_ready is low in the cycle after the accept; STOP coinciding with terminal count gives outdata=0 and no step_pulse.
REQ-037 Reset mid-RUN at 0x040: the next cycle shows all REQ-027 values; speed reads back 15 (first step after START is 64 clocks).
